// File: rtl/button_conditioner.sv
// Board push-button front end: a 2-flop sync, a debounce and an edge detect per button.
// Direction buttons also get an auto-repeat FSM and a one-hot priority arbiter (U > D > L > R).
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES      = 1000000,
  parameter int REPEAT_DELAY_CYCLES  = 50000000,
  parameter int REPEAT_PERIOD_CYCLES = 15000000,
  parameter int CNT_W                = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] btn_raw,
  output logic       btnL,
  output logic       btnR,
  output logic       btnU,
  output logic       btnD,
  output logic       placeMarker,
  output logic       resetGame,
  output logic [5:0] btn_level
);

  localparam int NUM_BTNS = 6;
  localparam int NUM_DIRS = 4;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_e;

  logic [NUM_BTNS-1:0] levelPrev, pressEv;
  logic [NUM_DIRS-1:0] dirReq, dirGrant;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_deb
    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             level;

    // A mismatch must hold for DEBOUNCE_CYCLES consecutive samples before it is
    // accepted; a single matching sample throws the count away.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync  <= '0;
        cnt   <= '0;
        level <= 1'b0;
      end else begin
        sync <= {sync[0], btn_raw[i]};
        if (sync[1] == level) begin
          cnt <= '0;
        end else if (cnt >= DEB_LAST) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign btn_level[i] = level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) levelPrev <= '0;
    else        levelPrev <= btn_level;
  end

  assign pressEv = btn_level & ~levelPrev;

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_rpt
    rpt_state_e       state, stateNxt;
    logic [CNT_W-1:0] cnt, cntNxt;
    logic             req;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= stateNxt;
        cnt   <= cntNxt;
      end
    end

    // A release drops to IDLE ahead of any terminal-count pulse in the same cycle.
    always_comb begin
      stateNxt = state;
      cntNxt   = cnt;
      req      = 1'b0;
      unique case (state)
        IDLE: begin
          cntNxt = '0;
          if (pressEv[d]) begin
            req      = 1'b1;
            stateNxt = DELAY;
          end
        end
        DELAY: begin
          if (!btn_level[d]) begin
            stateNxt = IDLE;
            cntNxt   = '0;
          end else if (cnt >= DLY_LAST) begin
            req      = 1'b1;
            stateNxt = REPEAT;
            cntNxt   = '0;
          end else begin
            cntNxt = cnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (!btn_level[d]) begin
            stateNxt = IDLE;
            cntNxt   = '0;
          end else if (cnt >= PER_LAST) begin
            req    = 1'b1;
            cntNxt = '0;
          end else begin
            cntNxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          stateNxt = IDLE;
          cntNxt   = '0;
        end
      endcase
    end

    assign dirReq[d] = req;
  end

  // Losers are simply dropped; their FSMs keep running.
  always_comb begin
    dirGrant = '0;
    if      (dirReq[2]) dirGrant[2] = 1'b1;
    else if (dirReq[3]) dirGrant[3] = 1'b1;
    else if (dirReq[0]) dirGrant[0] = 1'b1;
    else if (dirReq[1]) dirGrant[1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btnL        <= 1'b0;
      btnR        <= 1'b0;
      btnU        <= 1'b0;
      btnD        <= 1'b0;
      placeMarker <= 1'b0;
      resetGame   <= 1'b0;
    end else begin
      btnL        <= dirGrant[0];
      btnR        <= dirGrant[1];
      btnU        <= dirGrant[2];
      btnD        <= dirGrant[3];
      placeMarker <= pressEv[4];
      resetGame   <= pressEv[5];
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: each expected pulse is queued with its cycle
// number when the stimulus is driven, and it is compared against the outputs on every falling edge.
module tb_button_conditioner;
  localparam int DB = 4, RD = 10, RP = 3;
  localparam logic [5:0] ML = 6'h01, MR = 6'h02, MU = 6'h04, MD = 6'h08, MP = 6'h10;

  typedef struct {
    int         cyc;
    logic [5:0] mask;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] btn_raw = '0;
  logic       btnL, btnR, btnU, btnD, placeMarker, resetGame;
  logic [5:0] btn_level;
  logic [5:0] pulses, expP;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY_CYCLES(RD), .REPEAT_PERIOD_CYCLES(RP), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btnL(btnL), .btnR(btnR), .btnU(btnU), .btnD(btnD),
    .placeMarker(placeMarker), .resetGame(resetGame), .btn_level(btn_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign pulses = {resetGame, placeMarker, btnD, btnU, btnR, btnL};

  task automatic test_reset();
    btn_raw = '1;
    repeat (10) @(negedge clk);
    vectors++;
    if (btn_level !== 6'h00) begin
      miscompares++; $display("FAIL reset_level got=%b exp=000000", btn_level);
    end
    vectors++;
    if (pulses !== 6'h00) begin
      miscompares++; $display("FAIL reset_pulses got=%b exp=000000", pulses);
    end
    btn_raw = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      vectors++;
      if (pulses !== 6'h00 || btn_level !== 6'h00) begin
        miscompares++; $display("FAIL reset_idle cyc=%0d pulses=%b level=%b exp=0", cyc, pulses, btn_level);
      end
    end
  endtask

  task automatic test_place();
    int c0, c1;
    c0 = cyc;
    btn_raw[4] = 1'b1;
    sb.push_back('{c0 + 7, MP});
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      expP = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin expP = sb[0].mask; sb.delete(0); end
      vectors++;
      if (pulses !== expP) begin
        miscompares++; $display("FAIL place_pulse cyc=%0d got=%b exp=%b", cyc - c0, pulses, expP);
      end
      vectors++;
      if (btn_level[4] !== (cyc - c0 >= 6)) begin
        miscompares++; $display("FAIL place_level cyc=%0d got=%b exp=%b", cyc - c0, btn_level[4], (cyc - c0 >= 6));
      end
    end
    c1 = cyc;
    btn_raw[4] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      vectors++;
      if (pulses !== 6'h00) begin
        miscompares++; $display("FAIL release_pulse cyc=%0d got=%b exp=000000", cyc - c1, pulses);
      end
      vectors++;
      if (btn_level[4] !== (cyc - c1 < 6)) begin
        miscompares++; $display("FAIL release_level cyc=%0d got=%b exp=%b", cyc - c1, btn_level[4], (cyc - c1 < 6));
      end
    end
  endtask

  task automatic test_bounce();
    int c0;
    c0 = cyc;
    sb.push_back('{c0 + 15, ML});
    for (int k = 0; k < 35; k++) begin
      btn_raw[0] = (k < 8) ? ~k[1] : (k < 18);
      @(negedge clk);
      expP = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin expP = sb[0].mask; sb.delete(0); end
      vectors++;
      if (pulses !== expP) begin
        miscompares++; $display("FAIL bounce_pulse cyc=%0d got=%b exp=%b", cyc - c0, pulses, expP);
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL bounce_missing got=%0d left exp=0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_glitch();
    int c0;
    c0 = cyc;
    sb.push_back('{c0 + 33, 6'h20});
    for (int k = 0; k < 45; k++) begin
      btn_raw[5] = (k == 0) || (k >= 8 && k < 10) || (k >= 16 && k < 19) || (k >= 26 && k < 30);
      @(negedge clk);
      expP = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin expP = sb[0].mask; sb.delete(0); end
      vectors++;
      if (pulses !== expP) begin
        miscompares++; $display("FAIL glitch_pulse cyc=%0d got=%b exp=%b", cyc - c0, pulses, expP);
      end
      vectors++;
      if (btn_level[5] !== (cyc - c0 >= 32 && cyc - c0 < 36)) begin
        miscompares++; $display("FAIL glitch_level cyc=%0d got=%b", cyc - c0, btn_level[5]);
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL glitch_missing got=%0d left exp=0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_repeat();
    int c0;
    int t[8] = '{7, 17, 20, 23, 26, 29, 32, 35};
    c0 = cyc;
    foreach (t[j]) sb.push_back('{c0 + t[j], MU});
    for (int k = 0; k < 50; k++) begin
      btn_raw[2] = (k < 30);
      @(negedge clk);
      expP = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin expP = sb[0].mask; sb.delete(0); end
      vectors++;
      if (pulses !== expP) begin
        miscompares++; $display("FAIL repeat_pulse cyc=%0d got=%b exp=%b", cyc - c0, pulses, expP);
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL repeat_missing got=%0d left exp=0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_arbitration();
    int c0;
    int t[5] = '{7, 17, 20, 23, 26};
    c0 = cyc;
    foreach (t[j]) sb.push_back('{c0 + t[j], MU});
    for (int k = 0; k < 40; k++) begin
      btn_raw[2] = (k < 20);
      btn_raw[1] = (k < 8);
      @(negedge clk);
      expP = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin expP = sb[0].mask; sb.delete(0); end
      vectors++;
      if (pulses !== expP) begin
        miscompares++; $display("FAIL arb_ur_pulse cyc=%0d got=%b exp=%b", cyc - c0, pulses, expP);
      end
      vectors++;
      if (btn_level[1] !== (cyc - c0 >= 6 && cyc - c0 < 14)) begin
        miscompares++; $display("FAIL arb_r_level cyc=%0d got=%b", cyc - c0, btn_level[1]);
      end
    end
    c0 = cyc;
    sb.push_back('{c0 + 7, MD});
    for (int k = 0; k < 25; k++) begin
      btn_raw[3] = (k < 8);
      btn_raw[0] = (k < 8);
      @(negedge clk);
      expP = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin expP = sb[0].mask; sb.delete(0); end
      vectors++;
      if (pulses !== expP) begin
        miscompares++; $display("FAIL arb_dl_pulse cyc=%0d got=%b exp=%b", cyc - c0, pulses, expP);
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL arb_missing got=%0d left exp=0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_async_reset();
    int c0, r;
    c0 = cyc;
    sb.push_back('{c0 + 7, MD});
    sb.push_back('{c0 + 17, MD});
    sb.push_back('{c0 + 20, MD});
    btn_raw[3] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      expP = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin expP = sb[0].mask; sb.delete(0); end
      vectors++;
      if (pulses !== expP) begin
        miscompares++; $display("FAIL hold_pulse cyc=%0d got=%b exp=%b", cyc - c0, pulses, expP);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (pulses !== 6'h00 || btn_level !== 6'h00) begin
      miscompares++; $display("FAIL async_clear pulses=%b level=%b exp=0", pulses, btn_level);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (pulses !== 6'h00 || btn_level !== 6'h00) begin
      miscompares++; $display("FAIL async_hold pulses=%b level=%b exp=0", pulses, btn_level);
    end
    rst_n = 1'b1;
    r = cyc;
    sb.push_back('{r + 7, MD});
    for (int k = 0; k < 25; k++) begin
      btn_raw[3] = (k < 8);
      @(negedge clk);
      expP = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin expP = sb[0].mask; sb.delete(0); end
      vectors++;
      if (pulses !== expP) begin
        miscompares++; $display("FAIL post_reset_pulse cyc=%0d got=%b exp=%b", cyc - r, pulses, expP);
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL reset_missing got=%0d left exp=0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_concurrent();
    int c0;
    c0 = cyc;
    sb.push_back('{c0 + 7, MP | ML});
    for (int k = 0; k < 25; k++) begin
      btn_raw[4] = (k < 8);
      btn_raw[0] = (k < 8);
      @(negedge clk);
      expP = '0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin expP = sb[0].mask; sb.delete(0); end
      vectors++;
      if (pulses !== expP) begin
        miscompares++; $display("FAIL concurrent_pulse cyc=%0d got=%b exp=%b", cyc - c0, pulses, expP);
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL concurrent_missing got=%0d left exp=0", sb.size()); sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_place();
    test_bounce();
    test_glitch();
    test_repeat();
    test_arbitration();
    test_async_reset();
    test_concurrent();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
